// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline constants: datapath widths, register zero index and
// the write-back source select encoding also used by the control unit.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    // MemToReg encoding: which MEM/WB field feeds the register file.
    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    // Write-back source selection, kept here so the control unit and the
    // WB stage agree on the encoding.
    function automatic logic [DATA_W-1:0] wb_select(
        input logic              sel,
        input logic [DATA_W-1:0] mem_data,
        input logic [DATA_W-1:0] alu_data
    );
        return (sel == WB_SEL_MEM) ? mem_data : alu_data;
    endfunction

endpackage

// File: rtl/regfile_core.sv
// 2-read / 1-write register array with asynchronous clear. Entry 0 is not
// storage at all: it is tied to zero so no write can ever reach it.
module regfile_core
    import mips_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0] regs [NREG];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_store
                logic [DW-1:0] q_reg;

                // One architectural register: cleared by reset, loaded on a matching write.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_reg <= '0;
                    end else if (we && (waddr == AW'(gi))) begin
                        q_reg <= wdata;
                    end
                end

                assign regs[gi] = q_reg;
            end
        end
    endgenerate

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file of the 5-stage MIPS32
// pipeline. Picks the write-back value, commits it, forwards it to the ID
// read ports in the same cycle and counts retired register writes.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int CNT_W  = 16,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] R_data_RAM_MEM_WB,
    input  logic [DATA_W-1:0] result_ALU_MEM_WB,
    input  logic [ADDR_W-1:0] Instruccion_MUX_MEM_WB,
    input  logic              RegWrite_MEM_WB,
    input  logic              MemToReg_MEM_WB,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  wb_count
);

    logic              commit;
    logic [DATA_W-1:0] array_rs;
    logic [DATA_W-1:0] array_rt;
    logic [CNT_W-1:0]  count_reg;

    // Writes to r0 are dropped here, so they neither store nor count nor bypass.
    assign wb_data = (MemToReg_MEM_WB == WB_SEL_MEM) ? R_data_RAM_MEM_WB : result_ALU_MEM_WB;
    assign commit  = RegWrite_MEM_WB && (Instruccion_MUX_MEM_WB != ADDR_W'(REG_ZERO));

    regfile_core #(
        .DW (DATA_W),
        .AW (ADDR_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (commit),
        .waddr   (Instruccion_MUX_MEM_WB),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (array_rs),
        .rdata_b (array_rt)
    );

    // Write-first forwarding per read port, so ID sees this cycle's write-back.
    always_comb begin
        rs_data = array_rs;
        rt_data = array_rt;
        if (BYPASS && commit && (rs_addr == Instruccion_MUX_MEM_WB)) begin
            rs_data = wb_data;
        end
        if (BYPASS && commit && (rt_addr == Instruccion_MUX_MEM_WB)) begin
            rt_data = wb_data;
        end
    end

    // Retired-write counter; wraps naturally at 2**CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (commit) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign wb_count = count_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile. A second, narrow-counter instance shares the
// same stimulus so that counter wrap-around is reached in a few cycles.
`timescale 1ns/1ps
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic [31:0] ram_data;
    logic [31:0] alu_data;
    logic [4:0]  dst;
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data, rt_data, wb_data;
    logic [15:0] wb_count;
    logic [31:0] rs_data_n, rt_data_n, wb_data_n;
    logic [3:0]  wb_count_n;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(16), .BYPASS(1'b1)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .R_data_RAM_MEM_WB      (ram_data),
        .result_ALU_MEM_WB      (alu_data),
        .Instruccion_MUX_MEM_WB (dst),
        .RegWrite_MEM_WB        (reg_write),
        .MemToReg_MEM_WB        (mem_to_reg),
        .rs_addr                (rs_addr),
        .rt_addr                (rt_addr),
        .rs_data                (rs_data),
        .rt_data                (rt_data),
        .wb_data                (wb_data),
        .wb_count               (wb_count)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4), .BYPASS(1'b1)) dut_narrow (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .R_data_RAM_MEM_WB      (ram_data),
        .result_ALU_MEM_WB      (alu_data),
        .Instruccion_MUX_MEM_WB (dst),
        .RegWrite_MEM_WB        (reg_write),
        .MemToReg_MEM_WB        (mem_to_reg),
        .rs_addr                (rs_addr),
        .rt_addr                (rt_addr),
        .rs_data                (rs_data_n),
        .rt_data                (rt_data_n),
        .wb_data                (wb_data_n),
        .wb_count               (wb_count_n)
    );

    initial begin
        clk = 1'b0;
        #100;
        forever #5 clk = ~clk;
    end

    // An undefined write-back select is illegal whenever a write is requested.
    always @(posedge clk) begin
        if (reg_write === 1'b1) begin
            total++;
            assert (!$isunknown(mem_to_reg)) else begin
                bad++;
                $error("FAIL memtoreg_x observed=%b required=0/1", mem_to_reg);
            end
        end
    end

    task automatic expect_val(input string tag, input logic [31:0] v);
        sb_q.push_back('{tag, v});
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
            $display("check %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic [31:0] ram,
                         input logic [31:0] alu, input logic [4:0] d,
                         input logic [4:0] rs, input logic [4:0] rt);
        @(negedge clk);
        reg_write  = rw;
        mem_to_reg = m2r;
        ram_data   = ram;
        alu_data   = alu;
        dst        = d;
        rs_addr    = rs;
        rt_addr    = rt;
    endtask

    // Let the pending edge happen, then withdraw the write so reads see the array.
    task automatic clock_and_idle();
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        #1;
    endtask

    logic [15:0] cnt_model;

    initial begin
        rst_n = 1'b1; reg_write = 1'b0; mem_to_reg = 1'b0;
        ram_data = '0; alu_data = '0; dst = '0; rs_addr = '0; rt_addr = '0;
        cnt_model = '0;

        // 1. asynchronous reset without any clock edge
        #1 rst_n = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            expect_val($sformatf("reset_rs_r%0d", i), 32'h0);
            expect_val($sformatf("reset_rt_r%0d", 31 - i), 32'h0);
            check(rs_data);
            check(rt_data);
        end
        expect_val("reset_count", 32'h0);
        check({16'h0, wb_count});
        #10 rst_n = 1'b1;

        // 2. ALU write-back to r8
        drive(1'b1, 1'b0, 32'h0, 32'h0000_00AA, 5'd8, 5'd8, 5'd0);
        #1;
        expect_val("alu_wb_data", 32'h0000_00AA);
        check(wb_data);
        clock_and_idle();
        cnt_model++;
        expect_val("alu_read_r8", 32'h0000_00AA);
        expect_val("alu_count", 32'(cnt_model));
        check(rs_data);
        check({16'h0, wb_count});

        // 3. load write-back to r9 with both ports bypassing
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0055, 5'd9, 5'd9, 5'd9);
        #1;
        expect_val("load_bypass_rs", 32'hDEAD_BEEF);
        expect_val("load_bypass_rt", 32'hDEAD_BEEF);
        check(rs_data);
        check(rt_data);
        clock_and_idle();
        cnt_model++;
        expect_val("load_read_r9", 32'hDEAD_BEEF);
        expect_val("load_count", 32'(cnt_model));
        check(rt_data);
        check({16'h0, wb_count});

        // 4. write to r0 is discarded, no bypass
        drive(1'b1, 1'b0, 32'h0, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
        #1;
        expect_val("r0_wb_data", 32'h1234_5678);
        expect_val("r0_no_bypass", 32'h0);
        check(wb_data);
        check(rs_data);
        clock_and_idle();
        expect_val("r0_read", 32'h0);
        expect_val("r0_count", 32'(cnt_model));
        check(rs_data);
        check({16'h0, wb_count});

        // 5. RegWrite=0 changes nothing
        drive(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd8, 5'd8, 5'd9);
        #1;
        expect_val("gated_no_bypass_r8", 32'h0000_00AA);
        check(rs_data);
        @(posedge clk); #1;
        expect_val("gated_read_r8", 32'h0000_00AA);
        expect_val("gated_read_r9", 32'hDEAD_BEEF);
        expect_val("gated_count", 32'(cnt_model));
        check(rs_data);
        check(rt_data);
        check({16'h0, wb_count});

        // per-port bypass: only rs matches the destination
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0077, 5'd10, 5'd10, 5'd8);
        #1;
        expect_val("split_bypass_rs", 32'h0000_0077);
        expect_val("split_array_rt", 32'h0000_00AA);
        check(rs_data);
        check(rt_data);
        clock_and_idle();
        cnt_model++;

        // 6a. counter wrap, observed on the 4-bit instance
        for (int k = 0; k < 13; k++) begin
            drive(1'b1, 1'b0, 32'h0, 32'h100 + 32'(k), 5'(11 + k), 5'd0, 5'd0);
            @(posedge clk); #1;
            cnt_model++;
            expect_val($sformatf("narrow_count_k%0d", k), 32'(cnt_model[3:0]));
            check({28'h0, wb_count_n});
        end
        reg_write = 1'b0;
        #1;
        expect_val("wrap_main_count", 32'(cnt_model));
        check({16'h0, wb_count});
        rs_addr = 5'd11; rt_addr = 5'd23;
        #1;
        expect_val("burst_read_r11", 32'h100);
        expect_val("burst_read_r23", 32'h10C);
        check(rs_data);
        check(rt_data);

        // 6b. reset between edges with a commit pending
        drive(1'b1, 1'b0, 32'h0, 32'h0000_CAFE, 5'd5, 5'd8, 5'd9);
        #2 rst_n = 1'b0;
        #1;
        expect_val("midrst_r8", 32'h0);
        expect_val("midrst_r9", 32'h0);
        expect_val("midrst_count", 32'h0);
        check(rs_data);
        check(rt_data);
        check({16'h0, wb_count});
        @(posedge clk); #1;
        reg_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rs_addr = 5'd5; rt_addr = 5'd10;
        @(posedge clk); #1;
        expect_val("release_r5", 32'h0);
        expect_val("release_r10", 32'h0);
        expect_val("release_count", 32'h0);
        check(rs_data);
        check(rt_data);
        check({16'h0, wb_count});

        // first commit after release behaves normally
        drive(1'b1, 1'b1, 32'h0000_0011, 32'h0, 5'd5, 5'd5, 5'd0);
        clock_and_idle();
        expect_val("post_reset_r5", 32'h0000_0011);
        expect_val("post_reset_count", 32'h1);
        check(rs_data);
        check({16'h0, wb_count});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
